// File: rtl/rename_map_table_ckpt.sv
// Register rename map table with intra-group bypass, old-mapping outputs and
// CKPT_COUNT branch checkpoints offering single-cycle restore.
module rename_map_table_ckpt #(
  parameter int unsigned ARCH_COUNT   = 32,
  parameter int unsigned PHYS_COUNT   = 128,
  parameter int unsigned RENAME_WIDTH = 4,
  parameter int unsigned READ_PORTS   = 2 * RENAME_WIDTH,
  parameter int unsigned CKPT_COUNT   = 4,
  localparam int unsigned AW = $clog2(ARCH_COUNT),
  localparam int unsigned PW = $clog2(PHYS_COUNT),
  localparam int unsigned CW = $clog2(CKPT_COUNT)
) (
  input  logic                    clk,
  input  logic                    sync_rst,
  input  logic                    clk_en,
  input  logic [AW-1:0]           rd_arch [READ_PORTS],
  output logic [PW-1:0]           rd_phys [READ_PORTS],
  input  logic [RENAME_WIDTH-1:0] wr_en,
  input  logic [AW-1:0]           wr_arch [RENAME_WIDTH],
  input  logic [PW-1:0]           wr_phys [RENAME_WIDTH],
  output logic [PW-1:0]           old_phys [RENAME_WIDTH],
  input  logic                    ckpt_save,
  output logic [CW-1:0]           ckpt_id,
  output logic                    ckpt_full,
  input  logic                    restore_en,
  input  logic [CW-1:0]           restore_id,
  input  logic [CKPT_COUNT-1:0]   ckpt_release_mask,
  output logic [CKPT_COUNT-1:0]   ckpt_busy
);

  logic [PW-1:0]         table_q [ARCH_COUNT];
  logic [PW-1:0]         table_d [ARCH_COUNT];
  logic [PW-1:0]         ckpt_q  [CKPT_COUNT][ARCH_COUNT];
  logic [CKPT_COUNT-1:0] busy_q;
  logic [CKPT_COUNT-1:0] busy_d;
  logic                  do_restore;
  logic                  do_save;

  // Bypass: later matching slots overwrite earlier ones, so the youngest
  // older writer wins; slot k only feeds ports of strictly younger slots.
  always_comb begin
    for (int unsigned j = 0; j < READ_PORTS; j++) begin
      rd_phys[j] = table_q[rd_arch[j]];
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
        if (k < j / 2 && wr_en[k] && wr_arch[k] == rd_arch[j]) begin
          rd_phys[j] = wr_phys[k];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      old_phys[i] = table_q[wr_arch[i]];
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
        if (k < i && wr_en[k] && wr_arch[k] == wr_arch[i]) begin
          old_phys[i] = wr_phys[k];
        end
      end
    end
  end

  // Post-write table; ascending slot order gives highest-index WAW priority.
  always_comb begin
    table_d = table_q;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      if (wr_en[i]) begin
        table_d[wr_arch[i]] = wr_phys[i];
      end
    end
  end

  always_comb begin
    ckpt_id   = '0;
    ckpt_full = &busy_q;
    for (int unsigned n = CKPT_COUNT; n > 0; n--) begin
      if (!busy_q[n-1]) begin
        ckpt_id = CW'(n - 1);
      end
    end
  end

  always_comb begin
    do_restore = restore_en && busy_q[restore_id];
    do_save    = ckpt_save && !ckpt_full && !restore_en;
    busy_d     = busy_q & ~ckpt_release_mask;
    if (do_restore) begin
      busy_d[restore_id] = 1'b0;
    end
    if (do_save) begin
      busy_d[ckpt_id] = 1'b1;
    end
  end

  assign ckpt_busy = busy_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int unsigned a = 0; a < ARCH_COUNT; a++) begin
        table_q[a] <= PW'(a);
      end
      busy_q <= '0;
    end else if (clk_en) begin
      busy_q <= busy_d;
      if (do_restore) begin
        table_q <= ckpt_q[restore_id];
      end else if (!restore_en) begin
        table_q <= table_d;
      end
      if (do_save) begin
        ckpt_q[ckpt_id] <= table_d;
      end
    end
  end

endmodule

// File: tb/tb_rename_map_table_ckpt.sv
// Self-checking bench for rename_map_table_ckpt: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_rename_map_table_ckpt;

  localparam int unsigned ARCH = 32;
  localparam int unsigned PHYS = 128;
  localparam int unsigned RW   = 4;
  localparam int unsigned RP   = 8;
  localparam int unsigned CK   = 4;

  typedef int unsigned tab_t [ARCH];

  logic       clk = 1'b0;
  logic       sync_rst;
  logic       clk_en;
  logic [4:0] rd_arch [RP];
  logic [6:0] rd_phys [RP];
  logic [3:0] wr_en;
  logic [4:0] wr_arch [RW];
  logic [6:0] wr_phys [RW];
  logic [6:0] old_phys [RW];
  logic       ckpt_save;
  logic [1:0] ckpt_id;
  logic       ckpt_full;
  logic       restore_en;
  logic [1:0] restore_id;
  logic [3:0] ckpt_release_mask;
  logic [3:0] ckpt_busy;

  int checks   = 0;
  int failures = 0;

  tab_t     m_tab;
  tab_t     m_ck [CK];
  bit [3:0] m_busy;
  bit       m_valid = 1'b0;

  rename_map_table_ckpt #(
    .ARCH_COUNT(ARCH), .PHYS_COUNT(PHYS), .RENAME_WIDTH(RW),
    .READ_PORTS(RP), .CKPT_COUNT(CK)
  ) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .rd_arch(rd_arch), .rd_phys(rd_phys),
    .wr_en(wr_en), .wr_arch(wr_arch), .wr_phys(wr_phys), .old_phys(old_phys),
    .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .restore_en(restore_en), .restore_id(restore_id),
    .ckpt_release_mask(ckpt_release_mask), .ckpt_busy(ckpt_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Youngest enabled slot older than 'lim' renaming 'a', else the table entry.
  function automatic int unsigned lookup(int unsigned a, int unsigned lim);
    for (int k = int'(lim) - 1; k >= 0; k--)
      if (wr_en[k] && wr_arch[k] == a) return wr_phys[k];
    return m_tab[a];
  endfunction

  function automatic int unsigned first_free();
    for (int unsigned n = 0; n < CK; n++)
      if (!m_busy[n]) return n;
    return CK;
  endfunction

  task automatic idle();
    sync_rst = 0; clk_en = 1; wr_en = '0; ckpt_save = 0;
    restore_en = 0; restore_id = '0; ckpt_release_mask = '0;
    for (int unsigned j = 0; j < RP; j++) rd_arch[j] = '0;
    for (int unsigned i = 0; i < RW; i++) begin
      wr_arch[i] = '0; wr_phys[i] = '0;
    end
  endtask

  task automatic settle();
    #1;
    if (m_valid) begin
      for (int unsigned j = 0; j < RP; j++)
        chk($sformatf("rd_phys[%0d]", j), 32'(rd_phys[j]), lookup(rd_arch[j], j / 2));
      for (int unsigned i = 0; i < RW; i++)
        chk($sformatf("old_phys[%0d]", i), 32'(old_phys[i]), lookup(wr_arch[i], i));
      chk("ckpt_busy", 32'(ckpt_busy), 32'(m_busy));
      chk("ckpt_full", 32'(ckpt_full), 32'(m_busy == 4'hF));
      if (m_busy != 4'hF) chk("ckpt_id", 32'(ckpt_id), first_free());
    end
  endtask

  task automatic edge_step();
    tab_t post;
    int unsigned fid;
    bit rok;
    if (sync_rst) begin
      for (int unsigned a = 0; a < ARCH; a++) m_tab[a] = a;
      m_busy  = '0;
      m_valid = 1'b1;
    end else if (clk_en) begin
      fid  = first_free();
      post = m_tab;
      for (int unsigned i = 0; i < RW; i++)
        if (wr_en[i]) post[wr_arch[i]] = wr_phys[i];
      rok    = restore_en && m_busy[restore_id];
      m_busy = m_busy & ~ckpt_release_mask;
      if (rok) begin
        m_tab = m_ck[restore_id];
        m_busy[restore_id] = 1'b0;
      end else if (!restore_en) begin
        m_tab = post;
      end
      if (ckpt_save && fid < CK && !restore_en) begin
        m_ck[fid] = post;
        m_busy[fid] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); sync_rst = 1;
    settle(); edge_step();
    idle();
  endtask

  initial begin
    // Reset: identity table, no checkpoints busy
    idle(); sync_rst = 1; clk_en = 0;
    #1; edge_step(); idle();
    for (int unsigned g = 0; g < 4; g++) begin
      for (int unsigned j = 0; j < RP; j++) rd_arch[j] = 5'(g * 8 + j);
      settle();
      for (int unsigned j = 0; j < RP; j++)
        chk("reset_identity", 32'(rd_phys[j]), g * 8 + j);
    end
    chk("reset_busy", 32'(ckpt_busy), 0);
    chk("reset_id", 32'(ckpt_id), 0);
    chk("reset_full", 32'(ckpt_full), 0);

    // Intra-group bypass and WAW
    idle();
    wr_en = 4'b0101;
    wr_arch[0] = 5; wr_phys[0] = 40;
    wr_arch[2] = 5; wr_phys[2] = 41;
    rd_arch[1] = 5; rd_arch[3] = 5; rd_arch[7] = 5;
    settle();
    chk("byp_port1", 32'(rd_phys[1]), 5);
    chk("byp_port3", 32'(rd_phys[3]), 40);
    chk("byp_port7", 32'(rd_phys[7]), 41);
    chk("byp_old2", 32'(old_phys[2]), 40);
    edge_step(); idle();
    rd_arch[0] = 5; settle();
    chk("waw_table5", 32'(rd_phys[0]), 41);

    // Checkpoint then restore, with the restore-cycle write dropped
    do_reset();
    wr_en = 4'b0001; wr_arch[0] = 3; wr_phys[0] = 50; ckpt_save = 1;
    settle();
    chk("save_id", 32'(ckpt_id), 0);
    edge_step();
    chk("save_busy", 32'(ckpt_busy), 4'b0001);
    idle(); wr_en = 4'b0001; wr_arch[0] = 3; wr_phys[0] = 60;
    settle(); edge_step();
    idle(); restore_en = 1; restore_id = 0;
    wr_en = 4'b0001; wr_arch[0] = 3; wr_phys[0] = 70;
    settle(); edge_step();
    idle(); rd_arch[0] = 3; settle();
    chk("restore_r3", 32'(rd_phys[0]), 50);
    chk("restore_busy", 32'(ckpt_busy), 0);

    // Fill all checkpoints, overflow save, release/save in full cycle
    do_reset();
    for (int unsigned n = 0; n < CK; n++) begin
      ckpt_save = 1; settle(); edge_step();
    end
    chk("full_busy", 32'(ckpt_busy), 4'b1111);
    chk("full_flag", 32'(ckpt_full), 1);
    ckpt_save = 1; wr_en = 4'b0001; wr_arch[0] = 9; wr_phys[0] = 99;
    settle(); edge_step();
    chk("overflow_busy", 32'(ckpt_busy), 4'b1111);
    idle(); ckpt_save = 1; ckpt_release_mask = 4'b0100;
    settle(); edge_step();
    idle(); settle();
    chk("release_busy", 32'(ckpt_busy), 4'b1011);
    chk("release_id", 32'(ckpt_id), 2);

    // Release and save target the same slot: save wins
    do_reset();
    ckpt_save = 1; settle(); edge_step();
    idle(); ckpt_save = 1; ckpt_release_mask = 4'b0010;
    settle();
    chk("coll_id", 32'(ckpt_id), 1);
    edge_step();
    chk("coll_busy", 32'(ckpt_busy), 4'b0011);

    // clk_en low freezes state; reset still acts
    idle(); wr_en = 4'b0001; wr_arch[0] = 7; wr_phys[0] = 99;
    settle(); edge_step();
    idle(); clk_en = 0; wr_en = 4'b0011;
    wr_arch[0] = 7; wr_phys[0] = 11; wr_arch[1] = 8; wr_phys[1] = 12;
    ckpt_save = 1; restore_en = 1; restore_id = 0;
    settle(); edge_step();
    idle(); rd_arch[0] = 7; rd_arch[1] = 8; settle();
    chk("cen_r7", 32'(rd_phys[0]), 99);
    chk("cen_r8", 32'(rd_phys[1]), 8);
    chk("cen_busy", 32'(ckpt_busy), 4'b0011);
    clk_en = 0; sync_rst = 1; settle(); edge_step();
    idle(); rd_arch[0] = 7; settle();
    chk("cen_rst_r7", 32'(rd_phys[0]), 7);
    chk("cen_rst_busy", 32'(ckpt_busy), 0);

    // Randomized traffic against the model
    for (int unsigned c = 0; c < 400; c++) begin
      sync_rst   = ($urandom_range(0, 99) == 0);
      clk_en     = ($urandom_range(0, 9) != 0);
      wr_en      = 4'($urandom_range(0, 15));
      ckpt_save  = ($urandom_range(0, 2) == 0);
      restore_en = ($urandom_range(0, 7) == 0);
      restore_id = 2'($urandom_range(0, 3));
      ckpt_release_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      for (int unsigned i = 0; i < RW; i++) begin
        wr_arch[i] = 5'($urandom_range(0, 7));
        wr_phys[i] = 7'($urandom_range(0, PHYS - 1));
      end
      for (int unsigned j = 0; j < RP; j++)
        rd_arch[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, ARCH - 1))
                                                 : 5'($urandom_range(0, 7));
      settle();
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
